// File: rtl/gcd_sequencer.sv
`timescale 1ns/1ps
// Issues FIFO-buffered operand pairs to a gcd core via start/done, one trial at a time, and
// returns each result with its operands on a valid/ready port; a watchdog abandons silent trials.
module gcd_sequencer #(
   parameter int DEPTH   = 4,
   parameter int GAP     = 2,
   parameter int TIMEOUT = 1024,
   parameter int CW      = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_a,
   input  logic [31:0]   in_b,
   output logic          gcd_start,
   output logic [31:0]   gcd_a,
   output logic [31:0]   gcd_b,
   input  logic          gcd_done,
   input  logic [31:0]   gcd_result,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_a,
   output logic [31:0]   out_b,
   output logic [31:0]   out_result,
   output logic          out_timeout,
   output logic          busy,
   output logic [CW-1:0] trial_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int WW = $clog2(TIMEOUT) + 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
   localparam logic [WW-1:0] WD_MAX   = '1;
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_OUT, S_GAP} state_t;

   state_t        state_q, state_d;
   logic [63:0]   mem_q [DEPTH];
   logic [63:0]   mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [31:0]   gcd_a_q, gcd_a_d, gcd_b_q, gcd_b_d;
   logic [31:0]   out_a_q, out_a_d, out_b_q, out_b_d, out_result_q, out_result_d;
   logic          out_timeout_q, out_timeout_d;
   logic [WW-1:0] wd_q, wd_d, wd_inc;
   logic [GW-1:0] gap_q, gap_d;
   logic [CW-1:0] tc_q, tc_d;
   logic          push, pop, fifo_empty;

   assign fifo_empty  = (cnt_q == '0);
   assign in_ready    = (cnt_q != FULL_CNT);
   assign gcd_start   = (state_q == S_START);
   assign out_valid   = (state_q == S_OUT);
   assign busy        = (state_q != S_IDLE) || !fifo_empty;
   assign gcd_a       = gcd_a_q;
   assign gcd_b       = gcd_b_q;
   assign out_a       = out_a_q;
   assign out_b       = out_b_q;
   assign out_result  = out_result_q;
   assign out_timeout = out_timeout_q;
   assign trial_count = tc_q;
   // Saturating so a stuck comparison can never wrap back into a live count.
   assign wd_inc      = (wd_q == WD_MAX) ? wd_q : wd_q + WW'(1);

   always_comb begin
      push          = in_valid && in_ready;
      pop           = 1'b0;
      mem_d         = mem_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      cnt_d         = cnt_q;
      state_d       = state_q;
      gcd_a_d       = gcd_a_q;
      gcd_b_d       = gcd_b_q;
      out_a_d       = out_a_q;
      out_b_d       = out_b_q;
      out_result_d  = out_result_q;
      out_timeout_d = out_timeout_q;
      wd_d          = wd_q;
      gap_d         = gap_q;
      tc_d          = tc_q;

      if (push) begin
         mem_d[wr_ptr_q] = {in_a, in_b};
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop                = 1'b1;
               {gcd_a_d, gcd_b_d} = mem_q[rd_ptr_q];
               state_d            = S_START;
            end
         end
         S_START: begin
            wd_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            wd_d = wd_inc;
            if (gcd_done) begin
               out_result_d  = gcd_result;
               out_timeout_d = 1'b0;
               out_a_d       = gcd_a_q;
               out_b_d       = gcd_b_q;
               state_d       = S_OUT;
            end else if (wd_inc >= WD_LAST) begin
               out_result_d  = '0;
               out_timeout_d = 1'b1;
               out_a_d       = gcd_a_q;
               out_b_d       = gcd_b_q;
               state_d       = S_OUT;
            end
         end
         S_OUT: begin
            if (out_ready) begin
               tc_d    = tc_q + CW'(1);
               gap_d   = '0;
               state_d = (GAP == 0) ? S_IDLE : S_GAP;
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) state_d = S_IDLE;
            else gap_d = gap_q + GW'(1);
         end
         default: state_d = S_IDLE;
      endcase

      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop) cnt_d = cnt_q + (AW+1)'(1);
      else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         cnt_q         <= '0;
         gcd_a_q       <= '0;
         gcd_b_q       <= '0;
         out_a_q       <= '0;
         out_b_q       <= '0;
         out_result_q  <= '0;
         out_timeout_q <= 1'b0;
         wd_q          <= '0;
         gap_q         <= '0;
         tc_q          <= '0;
      end else begin
         state_q       <= state_d;
         mem_q         <= mem_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         cnt_q         <= cnt_d;
         gcd_a_q       <= gcd_a_d;
         gcd_b_q       <= gcd_b_d;
         out_a_q       <= out_a_d;
         out_b_q       <= out_b_d;
         out_result_q  <= out_result_d;
         out_timeout_q <= out_timeout_d;
         wd_q          <= wd_d;
         gap_q         <= gap_d;
         tc_q          <= tc_d;
      end
   end
endmodule

// File: tb/tb_gcd_sequencer.sv
`timescale 1ns/1ps
// Bench for gcd_sequencer: behavioural gcd core, queue scoreboard, vector table and corner sequences.
module tb_gcd_sequencer;
   localparam int DEPTH = 4, GAP = 2, TIMEOUT = 16, CW = 16;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
   } pair_t;
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      int          lat;
      logic [31:0] exp_res;
      logic        exp_to;
   } vec_t;

   logic clk = 0, reset_n = 0;
   logic in_valid = 0, in_ready, gcd_start, gcd_done = 0, out_valid, out_ready = 1;
   logic out_timeout, busy;
   logic [31:0] in_a = 0, in_b = 0, gcd_a, gcd_b, gcd_result = 0, out_a, out_b, out_result;
   logic [CW-1:0] trial_count;

   gcd_sequencer #(.DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b), .gcd_done(gcd_done), .gcd_result(gcd_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .out_result(out_result),
      .out_timeout(out_timeout), .busy(busy), .trial_count(trial_count));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int nchk = 0, nerr = 0;
   pair_t pq[$], iq[$];
   bit    tq[$];
   int    core_lat = 5, last_start = -1, n_starts = 0, n_hs = 0, out_rise = 0, hs_cyc = 0;
   logic [CW-1:0] tc = '0;
   logic [31:0]   last_res;
   logic          last_to;

   task automatic chk(input string nm, input bit ok, input logic [127:0] act, input logic [127:0] exp);
      nchk++;
      if (!ok) begin
         nerr++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic ceq(input string nm, input logic [127:0] act, input logic [127:0] exp);
      chk(nm, act === exp, act, exp);
   endtask

   function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x = a, y = b, t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input int lat,
                               input logic [31:0] r, input logic to);
      vec_t v;
      v.a = a; v.b = b; v.lat = lat; v.exp_res = r; v.exp_to = to;
      return v;
   endfunction

   // Behavioural core: done arrives lat cycles after the start cycle; lat<0 never answers.
   int clat;
   logic [31:0] ca, cb;
   always begin
      @(negedge clk);
      if (gcd_start) begin
         clat = (core_lat == -2) ? (($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, TIMEOUT - 1)))
                                 : core_lat;
         tq.push_back(clat < 1 || clat > TIMEOUT - 1);
         if (clat >= 0) begin
            ca = gcd_a;
            cb = gcd_b;
            repeat (clat) @(negedge clk);
            ceq("core_hold_a", gcd_a, ca);
            ceq("core_hold_b", gcd_b, cb);
            gcd_done = 1;
            gcd_result = ref_gcd(ca, cb);
            @(negedge clk);
            gcd_done = 0;
            gcd_result = 32'hdeadbeef;
         end
      end
   end

   pair_t mp;
   bit    mto;
   logic  prev_vld = 0, prev_rdy = 0;
   logic [96:0] held = '0;
   always begin
      @(negedge clk);
      #1;
      if (reset_n) begin
         if (gcd_start) begin
            chk("start_expected", iq.size() != 0, iq.size(), 1);
            if (iq.size() != 0) begin
               mp = iq.pop_front();
               ceq("start_a", gcd_a, mp.a);
               ceq("start_b", gcd_b, mp.b);
            end
            if (last_start >= 0) chk("start_spacing", cyc - last_start >= 4 + GAP, cyc - last_start, 4 + GAP);
            last_start = cyc;
            n_starts++;
         end
         if (out_valid && !prev_vld) out_rise = cyc;
         if (out_valid && prev_vld && !prev_rdy)
            ceq("out_stable", {out_a, out_b, out_result, out_timeout}, held);
         if (out_valid && out_ready) begin
            chk("out_expected", pq.size() != 0 && tq.size() != 0, pq.size(), 1);
            if (pq.size() != 0 && tq.size() != 0) begin
               mp = pq.pop_front();
               mto = tq.pop_front();
               ceq("sb_a", out_a, mp.a);
               ceq("sb_b", out_b, mp.b);
               ceq("sb_timeout", out_timeout, mto);
               ceq("sb_result", out_result, mto ? 32'd0 : ref_gcd(mp.a, mp.b));
               ceq("sb_count", trial_count, tc);
            end
            tc = tc + 1'b1;
            hs_cyc = cyc;
            last_res = out_result;
            last_to = out_timeout;
            n_hs++;
         end
         prev_vld = out_valid;
         prev_rdy = out_ready;
         held = {out_a, out_b, out_result, out_timeout};
      end else begin
         prev_vld = 0;
      end
   end

   // Called at a negedge; returns at the negedge after acceptance with in_valid dropped.
   task automatic push(input logic [31:0] a, input logic [31:0] b, output int acc);
      int t = 0;
      pair_t p;
      in_valid = 1; in_a = a; in_b = b;
      while (!in_ready && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk("push_accept", in_ready, in_ready, 1);
      acc = cyc;
      p.a = a; p.b = b;
      pq.push_back(p);
      iq.push_back(p);
      @(negedge clk);
      in_valid = 0;
   endtask

   task automatic wait_hs(input int tgt, input int budget);
      int t = 0;
      while (n_hs < tgt && t < budget) begin
         @(negedge clk);
         t++;
      end
      chk("hs_reached", n_hs >= tgt, n_hs, tgt);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("idle_reached", !busy, busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got cycle %0d, want finish", cyc);
      $fatal(1);
   end

   vec_t vt[$];
   int acc, acc2, h0, s0, s1, t, nvec, e;
   int accs[5];
   bit stop_rdy;
   logic [31:0] m;

   initial begin
      vt.push_back(mk(48, 18, 5, 6, 0));
      vt.push_back(mk(17, 5, 1, 1, 0));
      vt.push_back(mk(100, 75, 15, 25, 0));   // done coincides with watchdog expiry
      vt.push_back(mk(12, 8, -1, 0, 1));
      vt.push_back(mk(9, 6, 0, 0, 1));        // done only during START is ignored
      vt.push_back(mk(0, 9, 3, 9, 0));
      vt.push_back(mk(81, 27, 2, 27, 0));
      vt.push_back(mk(1071, 462, 14, 21, 0));
      nvec = vt.size();

      repeat (3) @(negedge clk);
      #1;
      ceq("rst_start", gcd_start, 0);
      ceq("rst_out_valid", out_valid, 0);
      ceq("rst_busy", busy, 0);
      ceq("rst_count", trial_count, 0);
      ceq("rst_regs", {gcd_a, gcd_b, out_a, out_b, out_result, out_timeout}, 0);
      reset_n = 1;
      @(negedge clk);
      ceq("rst_in_ready", in_ready, 1);

      for (int i = 0; i < nvec; i++) begin
         wait_idle();
         core_lat = vt[i].lat;
         h0 = n_hs;
         push(vt[i].a, vt[i].b, acc);
         wait_hs(h0 + 1, 200);
         ceq("vec_start_lat", last_start, acc + 2);
         e = (vt[i].lat >= 1 && vt[i].lat <= TIMEOUT - 1) ? last_start + vt[i].lat + 1 : last_start + TIMEOUT;
         ceq("vec_out_lat", out_rise, e);
         ceq("vec_result", last_res, vt[i].exp_res);
         ceq("vec_timeout", last_to, vt[i].exp_to);
         ceq("vec_count", trial_count, i + 1);
      end

      // Consumer backpressure with a second pair queued behind.
      wait_idle();
      out_ready = 0;
      core_lat = 3;
      h0 = n_hs;
      push(60, 45, acc);
      push(21, 14, acc2);
      t = 0;
      while (!out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      ceq("bp_valid_rise", out_valid, 1);
      s0 = n_starts;
      repeat (10) @(negedge clk);
      ceq("bp_no_start", n_starts, s0);
      ceq("bp_valid_held", out_valid, 1);
      ceq("bp_count_held", trial_count, nvec);
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      t = 0;
      while (n_starts == s0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      ceq("bp_next_start", last_start, hs_cyc + GAP + 2);
      ceq("bp_count_once", trial_count, nvec + 1);
      ceq("bp_result", last_res, 15);
      out_ready = 1;
      wait_hs(h0 + 2, 100);
      ceq("bp_result2", last_res, 7);

      // Stalled core: four pairs fill the FIFO behind one in flight.
      wait_idle();
      core_lat = -1;
      h0 = n_hs;
      for (int i = 0; i < 5; i++) begin
         push(100 + i, 200 + i, accs[i]);
         ceq("stall_b2b_accept", accs[i], accs[0] + i);
      end
      ceq("stall_full", in_ready, 0);
      push(300, 400, acc);
      ceq("stall_late_accept", acc, accs[0] + 2 + TIMEOUT + GAP + 2);
      wait_hs(h0 + 6, 400);
      ceq("stall_count", trial_count, nvec + 8);

      // Reset in the middle of a WAIT with two pairs still queued.
      wait_idle();
      core_lat = -1;
      s0 = n_starts;
      for (int i = 0; i < 3; i++) push(7 * (i + 1), 5, acc);
      t = 0;
      while (n_starts == s0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      #3;
      reset_n = 0;
      #1;
      ceq("mid_rst_start", gcd_start, 0);
      ceq("mid_rst_valid", out_valid, 0);
      ceq("mid_rst_busy", busy, 0);
      ceq("mid_rst_in_ready", in_ready, 1);
      ceq("mid_rst_count", trial_count, 0);
      pq.delete();
      iq.delete();
      tq.delete();
      tc = '0;
      last_start = -1;
      @(negedge clk);
      reset_n = 1;
      s1 = n_starts;
      repeat (30) @(negedge clk);
      ceq("post_rst_no_issue", n_starts, s1);
      ceq("post_rst_busy", busy, 0);
      ceq("post_rst_in_ready", in_ready, 1);

      // Random pairs, random core latency, random consumer stalls.
      core_lat = -2;
      stop_rdy = 0;
      h0 = n_hs;
      fork
         begin
            while (!stop_rdy) begin
               @(negedge clk);
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
         begin
            for (int i = 0; i < 24; i++) begin
               m = $urandom_range(1, 50);
               push(m * $urandom_range(1, 200), m * $urandom_range(1, 200), acc);
               repeat ($urandom_range(0, 8)) @(negedge clk);
            end
            wait_hs(h0 + 24, 24 * 60);
            stop_rdy = 1;
         end
      join
      out_ready = 1;
      wait_idle();
      ceq("rand_count", trial_count, 24);
      ceq("rand_drained", pq.size(), 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/gcd_sequencer.md
Name: gcd_sequencer

Overview:
- Synthesizable initiator for the gcd unit's start/done handshake. It performs in hardware the job the bench does today: issue operands, pulse start, wait for done, collect the result.
- Operand pairs arrive through a valid/ready input buffered by a small FIFO. Each pair is issued to the gcd core in order. The result leaves on a valid/ready output together with its operands.
- A watchdog flags a core that never asserts done.

Parameters:
- DEPTH, 4, operand FIFO entries (power of 2, at least 2)
- GAP, 2, idle cycles between completing one trial and issuing the next
- TIMEOUT, 1024, maximum WAIT cycles before the trial is abandoned
- CW, 16, width of the completed-trial counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  FIFO can accept a pair
- in_a  in  32  operand a
- in_b  in  32  operand b
- gcd_start  out  1  one-cycle start pulse to the gcd core
- gcd_a  out  32  operand a to the core, held from start until done
- gcd_b  out  32  operand b to the core, held from start until done
- gcd_done  in  1  completion from the core
- gcd_result  in  32  core result, valid while gcd_done=1
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_a  out  32  operand a of the reported trial
- out_b  out  32  operand b of the reported trial
- out_result  out  32  captured result
- out_timeout  out  1  trial abandoned by the watchdog
- busy  out  1  state is not IDLE, or FIFO is non-empty
- trial_count  out  CW  completed trials; wraps at 2^CW, includes timed-out trials

Behaviour:
- Reset (asynchronous, applied any time, including mid-trial):
  - State goes to IDLE; FIFO is emptied.
  - gcd_start=0, out_valid=0, out_timeout=0, trial_count=0.
  - gcd_a, gcd_b, out_a, out_b, out_result all =0.
  - in_ready=1 once reset_n=1. busy=0.
- FIFO:
  - Push when in_valid && in_ready. in_ready = !full, registered count.
  - No push while full; a pair offered while full stays pending on the input, with nothing lost or overwritten.
  - Only IDLE pops, and only when the FIFO is non-empty.
  - Push and pop in the same cycle leave the count unchanged.
  - Order is strictly FIFO.
- State machine: IDLE, START, WAIT, OUT, GAP.
  - IDLE: if the FIFO is non-empty, pop the head into gcd_a/gcd_b and go to START.
  - START: gcd_start=1 for exactly this one cycle; watchdog cleared; go to WAIT. gcd_done is ignored in START.
  - WAIT: watchdog increments each cycle.
    - If gcd_done=1: capture out_result=gcd_result, out_timeout=0, out_a/out_b=gcd_a/gcd_b; go to OUT.
    - Otherwise, if the watchdog reaches TIMEOUT-1: capture out_result=0, out_timeout=1; go to OUT.
    - If done and timeout coincide, done wins.
  - OUT: out_valid=1. out_a, out_b, out_result and out_timeout are held stable until out_ready=1. On handshake, increment trial_count and go to GAP, or to IDLE when GAP=0.
  - GAP: count GAP cycles, then go to IDLE.
- gcd_a/gcd_b change only on the IDLE pop; they stay stable through START, WAIT, OUT and GAP.
- Latency:
  - Push in cycle N with IDLE and an empty FIFO → gcd_start=1 in cycle N+2.
  - gcd_done first seen in WAIT in cycle M → out_valid=1 in cycle M+1.
  - Issue-to-issue spacing is at least 4+GAP cycles.
- out_valid is not combinationally dependent on out_ready.
- Width/arithmetic: the watchdog is clog2(TIMEOUT)+1 bits and saturates. trial_count wraps from 2^CW-1 to 0.

Test Plan:
- Push (48,18); core asserts done after 5 WAIT cycles with result 6 → gcd_start high exactly 1 cycle, at push cycle +2. out_valid=1 with out_a=48, out_b=18, out_result=6, out_timeout=0. trial_count=1.
- Push 5 pairs back-to-back with the core stalled (DEPTH=4) → in_ready=0 after 4 entries plus 1 issued. The 5th pair is accepted later. The five results emerge in push order; gcd_start pulses are spaced by at least 6 cycles.
- Hold out_ready=0 for 10 cycles after out_valid rises → outputs stable. No new gcd_start until the handshake plus GAP=2 cycles. trial_count increments once.
- gcd_done never asserted, TIMEOUT=16 → out_valid rises 16 cycles after START with out_result=0 and out_timeout=1. The next pair then issues normally.
- Assert reset_n=0 in WAIT with 2 pairs still queued → gcd_start, out_valid and busy go to 0 immediately. After release, in_ready=1 and no stale trial is issued.
- gcd_done=1 in the same cycle the watchdog expires → out_timeout=0 and out_result=gcd_result.
